uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 16: clock cycles per serial bit, legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: transmit buffer entries, power of two, range 2..16.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port dataIn  input  8: byte to transmit.
REQ-006 SHALL have port dataValid  input  1: dataIn valid this cycle.
REQ-007 SHALL have port dataReady  output  1: buffer can accept a byte this cycle.
REQ-008 SHALL have port serialOutput  output  1: line to the downstream UART receiver; idle high.
REQ-009 SHALL have port busy  output  1: frame in flight or buffer non-empty.

Function
REQ-010 SHALL accept a byte on a posedge where dataValid and dataReady are both 1, and write it into the FIFO at that edge.
REQ-011 SHALL drive dataReady = !full, combinationally from the registered FIFO count.
REQ-012 SHALL block a push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-013 SHALL leave the count unchanged on a simultaneous push and pop with a non-empty FIFO, and SHALL commit both.
REQ-014 SHALL use FSM states IDLE, START, DATA, STOP, held in a 2-bit register.
REQ-015 From IDLE with the FIFO non-empty at an edge, SHALL pop the head word into the shift register, enter START, and register serialOutput=0 at that same edge.
REQ-016 SHALL hold each bit (start, 8 data, stop) for exactly CLOCKS_PER_BIT cycles, counted by an 8-bit bit-period counter that clears at each bit boundary.
REQ-017 In DATA, SHALL send data bits LSB first, indexed by a 3-bit bitIndex; after bit 7 completes, SHALL enter STOP with serialOutput=1.
REQ-018 At the end of STOP, with the FIFO non-empty, SHALL pop and go directly to START with no idle cycle; with the FIFO empty, SHALL go to IDLE.
REQ-019 SHALL give a frame a length of exactly 10*CLOCKS_PER_BIT cycles.
REQ-020 SHALL drive serialOutput low at the edge after acceptance (latency 1 cycle) when the byte is accepted into an empty FIFO while in IDLE.
REQ-021 SHALL drive serialOutput from a register, glitch-free, and SHALL hold it 1 in IDLE.
REQ-022 SHALL drive busy = (state != IDLE) || (count != 0).
REQ-023 SHALL ignore changes to dataIn while a frame is in flight; the shift register alone feeds the line.
REQ-024 SHALL recover any illegal FSM encoding to IDLE on the next edge, with serialOutput=1.
REQ-025 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH, and SHALL make the count FIFO_DEPTH+1 values wide.

Reset
REQ-026 On rst assertion, SHALL immediately set state=IDLE, serialOutput=1, counters=0, bitIndex=0, FIFO pointers and count=0, and the shift register to 0.
REQ-027 SHALL abort a frame cut by a mid-frame reset, return the line high at once, and discard buffered bytes.
REQ-028 SHALL drive dataReady=1 and busy=0 from reset release onward.

Structure
REQ-029 SHALL take the state encoding (IDLE=0, START=1, DATA=2, STOP=3) and the CLOCKS_PER_BIT default from a shared uart_pkg, also used by the UART receiver.
REQ-030 SHALL implement the FIFO as sub-module uart_tx_fifo with push/pop/full/empty/count; the FSM and shift register SHALL stay in uart_tx.

Verification
REQ-031 CPB=16, push 0xA5 at cycle 0 -> serialOutput low at cycle 1, then 0,1,0,1,0,0,1,0,1,1 in 16-cycle bits; busy drops at cycle 161.
REQ-032 Push 0x00 then 0xFF back-to-back -> 320 contiguous cycles, no idle gap, second start bit immediately after the first stop bit.
REQ-033 Hold dataValid for 6 consecutive cycles from idle -> 5 bytes accepted, dataReady low on cycle 5, 6th accepted only after the first frame ends.
REQ-034 Assert rst at cycle 40 of a 0x3C frame -> serialOutput=1 same cycle, busy=0, no further edges on the line.
REQ-035 Loop serialOutput into the UART receiver with matching bit period, send 0x3C, 0x81, 0x7E -> receiver reports the same three bytes in order.
REQ-036 CPB=2, push 0x55 -> frame exactly 20 cycles, alternating bits after start.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding
// and the default bit period, used by TX and RX.
package uart_pkg;

  localparam int CPB_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer, power-of-two depth.
// Ports: i_push/i_data write, i_pop reads o_data
// (head word), o_full/o_empty/o_count status.
module uart_tx_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [7:0]    i_data,
  input  logic          i_pop,
  output logic [7:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];

  // Full blocks a push even when a pop
  // happens at the same edge.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter.
// Ports: dataIn/dataValid/dataReady byte input,
// serialOutput line (idle high), busy status.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = CPB_DEFAULT,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dataIn,
  input  logic       dataValid,
  output logic       dataReady,
  output logic       serialOutput,
  output logic       busy
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [7:0] LAST =
    8'(CLOCKS_PER_BIT - 1);

  uart_state_t   r_state;
  logic [7:0]    r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_txd;

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_head;
  logic          w_bit_end;
  logic          w_pop;
  logic [2:0]    w_next_idx;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (dataValid),
    .i_data  (dataIn),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_bit_end  = (r_cnt == LAST);
  assign w_next_idx = r_bit_idx + 3'd1;

  // Pop from IDLE, or at the end of a stop bit
  // so the next start bit follows with no gap.
  assign w_pop = !w_empty &&
    ((r_state == ST_IDLE) ||
     ((r_state == ST_STOP) && w_bit_end));

  assign dataReady    = !w_full;
  assign serialOutput = r_txd;
  assign busy = (r_state != ST_IDLE) ||
                (w_count != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_txd     <= 1'b1;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= ST_START;
            r_txd   <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
            r_txd     <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_bit_idx <= w_next_idx;
              r_txd     <= r_shift[w_next_idx];
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_STOP: begin
          if (w_bit_end) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= ST_START;
              r_txd   <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_txd   <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_txd     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: CPB=16 and CPB=2
// instances, framing, back-pressure, reset abort.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic       dv  = 1'b0;
  logic       rdy;
  logic       txd;
  logic       bsy;
  logic [7:0] din2 = 8'h00;
  logic       dv2  = 1'b0;
  logic       rdy2;
  logic       txd2;
  logic       bsy2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .CLOCKS_PER_BIT (16),
    .FIFO_DEPTH     (4)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .dataIn       (din),
    .dataValid    (dv),
    .dataReady    (rdy),
    .serialOutput (txd),
    .busy         (bsy)
  );

  uart_tx #(
    .CLOCKS_PER_BIT (2),
    .FIFO_DEPTH     (4)
  ) u_cpb2 (
    .clk          (clk),
    .rst          (rst),
    .dataIn       (din2),
    .dataValid    (dv2),
    .dataReady    (rdy2),
    .serialOutput (txd2),
    .busy         (bsy2)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Line receiver: finds a start bit, samples
  // mid-bit, returns on the last stop cycle.
  task automatic rx_byte(
    output logic [7:0] b,
    output logic       ok
  );
    int g;
    g  = 0;
    ok = 1'b1;
    b  = 8'h00;
    while (txd !== 1'b0 && g < 400) begin
      tick();
      g++;
    end
    if (txd !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    ticks(8);
    if (txd !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      ticks(16);
      b[k] = txd;
    end
    ticks(16);
    if (txd !== 1'b1) ok = 1'b0;
    ticks(7);
  endtask

  initial begin
    logic [7:0] rb;
    logic       ok;
    logic [7:0] pat;
    logic [7:0] exp_b [3];
    logic       e_bit;
    int         acc;
    int         w;
    int         lows;

    // Reset
    ticks(2);
    rst = 1'b0;
    tick();
    chk("rst_txd", 32'(txd), 1);
    chk("rst_rdy", 32'(rdy), 1);
    chk("rst_busy", 32'(bsy), 0);
    chk("rst_txd2", 32'(txd2), 1);

    // 0xA5, then garbage on dataIn mid-frame
    din = 8'hA5;
    dv  = 1'b1;
    tick();
    dv  = 1'b0;
    din = 8'hFF;
    chk("a5_c0_txd", 32'(txd), 1);
    chk("a5_c0_busy", 32'(bsy), 1);
    tick();
    chk("a5_c1_txd", 32'(txd), 0);
    rx_byte(rb, ok);
    chk("a5_ok", 32'(ok), 1);
    chk("a5_byte", 32'(rb), 32'hA5);
    chk("a5_c160_busy", 32'(bsy), 1);
    tick();
    chk("a5_c161_busy", 32'(bsy), 0);
    chk("a5_c161_txd", 32'(txd), 1);
    ticks(3);

    // 0x00 then 0xFF back to back
    din = 8'h00;
    dv  = 1'b1;
    tick();
    din = 8'hFF;
    tick();
    dv  = 1'b0;
    chk("b2b_start", 32'(txd), 0);
    rx_byte(rb, ok);
    chk("b2b_ok0", 32'(ok), 1);
    chk("b2b_byte0", 32'(rb), 32'h00);
    tick();
    chk("b2b_nogap", 32'(txd), 0);
    rx_byte(rb, ok);
    chk("b2b_ok1", 32'(ok), 1);
    chk("b2b_byte1", 32'(rb), 32'hFF);
    chk("b2b_c320_busy", 32'(bsy), 1);
    tick();
    chk("b2b_c321_busy", 32'(bsy), 0);
    ticks(3);

    // dataValid held for 6 cycles
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      din = 8'(i + 1);
      dv  = 1'b1;
      if (i == 5) chk("bp_rdy_c5", 32'(rdy), 0);
      if (rdy) acc++;
      tick();
    end
    chk("bp_accepted", 32'(acc), 5);
    w = 0;
    while (!rdy && w < 300) begin
      tick();
      w++;
    end
    chk("bp_wait", 32'(w), 156);
    tick();
    dv = 1'b0;
    chk("bp_full_again", 32'(rdy), 0);
    w = 0;
    while (bsy && w < 1200) begin
      tick();
      w++;
    end
    chk("bp_drain_busy", 32'(bsy), 0);
    chk("bp_drain_rdy", 32'(rdy), 1);
    ticks(3);

    // Loopback of three bytes
    exp_b[0] = 8'h3C;
    exp_b[1] = 8'h81;
    exp_b[2] = 8'h7E;
    dv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = exp_b[i];
      tick();
    end
    dv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_byte(rb, ok);
      chk("lb_ok", 32'(ok), 1);
      chk("lb_byte", 32'(rb), 32'(exp_b[i]));
    end
    ticks(5);
    chk("lb_idle", 32'(bsy), 0);

    // CPB=2, 0x55
    pat  = 8'h55;
    din2 = 8'h55;
    dv2  = 1'b1;
    tick();
    dv2  = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e <= 2)       e_bit = 1'b0;
      else if (e >= 19) e_bit = 1'b1;
      else              e_bit = pat[(e - 3) / 2];
      chk($sformatf("cpb2_c%0d", e),
          32'(txd2), 32'(e_bit));
    end
    chk("cpb2_c20_busy", 32'(bsy2), 1);
    tick();
    chk("cpb2_c21_busy", 32'(bsy2), 0);
    chk("cpb2_c21_txd", 32'(txd2), 1);
    ticks(3);

    // Reset mid-frame with bytes buffered
    dv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = exp_b[i];
      tick();
    end
    dv = 1'b0;
    ticks(38);
    chk("rst_pre_txd", 32'(txd), 0);
    chk("rst_pre_busy", 32'(bsy), 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_txd", 32'(txd), 1);
    chk("rst_mid_busy", 32'(bsy), 0);
    chk("rst_mid_rdy", 32'(rdy), 1);
    tick();
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (txd !== 1'b1) lows++;
    end
    chk("rst_quiet", 32'(lows), 0);
    chk("rst_post_busy", 32'(bsy), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
